seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment display driver, the next generation of the board's fixed 8-digit hex scanner. Scans DIGITS common-anode digits from a tear-free shadow copy of the displayed value, with per-digit decimal points, optional leading-zero blanking and PWM brightness. Sits between CPU-side debug data (LED data, PC) and the board AN/SEG pins, clocked directly from the board clock.

---
 rtl/seg_scan_display.sv | 139 +++++++++++++
 tb/tb_seg_scan_display.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: tear-free staged value, per-digit decimal points,
// leading-zero blanking and PWM brightness. All outputs are registered, active low.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 16,
  parameter int DIM_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic                  update,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int K  = CW - DIM_BITS;

  logic [CW-1:0]       cnt_r;
  logic [PW-1:0]       pos_r;
  logic [4*DIGITS-1:0] stg_num_r;
  logic [DIGITS-1:0]   stg_dp_r;
  logic                stg_blz_r;
  logic [4*DIGITS-1:0] disp_num_r;
  logic [DIGITS-1:0]   disp_dp_r;
  logic                disp_blz_r;

  logic                tick_s;
  logic                boundary_s;
  logic                lit_s;
  logic [DIGITS-1:0]   blank_s;
  logic [3:0]          cur_nib_s;
  logic [6:0]          cur_seg_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h18;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      4'hF:    hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  assign tick_s     = (cnt_r == CW'(SCAN_DIV - 1));
  assign boundary_s = tick_s && (pos_r == PW'(DIGITS - 1));
  assign lit_s      = (DIM_BITS'(cnt_r >> K) <= brightness);
  assign cur_nib_s  = disp_num_r[{pos_r, 2'b00} +: 4];

  // A digit above 0 blanks when it and every more-significant nibble are zero.
  always_comb begin : blank_calc
    logic zero_s;
    zero_s  = 1'b1;
    blank_s = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_s     = zero_s && (disp_num_r[4*i +: 4] == 4'h0);
      blank_s[i] = disp_blz_r && zero_s;
    end
  end

  // Segment pattern for the digit currently being scanned.
  always_comb begin
    if (blank_s[pos_r]) begin
      cur_seg_s = 7'h7F;
    end else begin
      cur_seg_s = hex_to_seg(cur_nib_s);
    end
  end

  // Prescaler, scan position, staging/display handoff and registered pin drive.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt_r      <= '0;
      pos_r      <= '0;
      stg_num_r  <= '0;
      stg_dp_r   <= '0;
      stg_blz_r  <= 1'b0;
      disp_num_r <= '0;
      disp_dp_r  <= '0;
      disp_blz_r <= 1'b0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an         <= {DIGITS{1'b1}};
      seg        <= 8'hFF;
    end else begin
      cnt_r <= tick_s ? '0 : cnt_r + CW'(1);
      if (tick_s) begin
        pos_r <= (pos_r == PW'(DIGITS - 1)) ? '0 : pos_r + PW'(1);
      end

      if (update) begin
        stg_num_r <= num;
        stg_dp_r  <= dp;
        stg_blz_r <= blank_lz;
      end

      // A coinciding update keeps pending set while the older staging is applied.
      if (boundary_s && pending) begin
        disp_num_r <= stg_num_r;
        disp_dp_r  <= stg_dp_r;
        disp_blz_r <= stg_blz_r;
      end
      if (update) begin
        pending <= 1'b1;
      end else if (boundary_s) begin
        pending <= 1'b0;
      end

      frame_done <= boundary_s;

      if (lit_s) begin
        an  <= ~(DIGITS'(1) << pos_r);
        seg <= {~disp_dp_r[pos_r], cur_seg_s};
      end else begin
        an  <= {DIGITS{1'b1}};
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=4, SCAN_DIV=16, DIM_BITS=2.
module tb_seg_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 16;
  localparam int DIM_BITS = 2;

  logic                CLK = 1'b0;
  logic                rst;
  logic [15:0]         num;
  logic [3:0]          dp;
  logic                blank_lz;
  logic                update;
  logic [1:0]          brightness;
  logic [3:0]          an;
  logic [7:0]          seg;
  logic                pending;
  logic                frame_done;

  int checks = 0;
  int passed = 0;
  int n;

  seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DIM_BITS(DIM_BITS)) dut (
    .CLK(CLK), .rst(rst), .num(num), .dp(dp), .blank_lz(blank_lz), .update(update),
    .brightness(brightness), .an(an), .seg(seg), .pending(pending), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    check({tag, "_an"}, {28'd0, an}, {28'd0, exp_an});
    check({tag, "_seg"}, {24'd0, seg}, {24'd0, exp_seg});
  endtask

  // Steps until the next frame_done pulse; returns the number of cycles taken.
  task automatic wait_frame(output int cycles);
    logic got;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < 200) begin
      step(1);
      cycles++;
      got = frame_done;
    end
    check("frame_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic do_update(input logic [15:0] v, input logic [3:0] d, input logic b);
    num      = v;
    dp       = d;
    blank_lz = b;
    update   = 1'b1;
    step(1);
    update   = 1'b0;
  endtask

  task automatic pwm(input logic [1:0] b, input int exp_lit);
    int lit;
    int bad;
    lit = 0;
    bad = 0;
    brightness = b;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (an !== 4'hF) lit++;
      if ((an === 4'hF) != (seg === 8'hFF)) bad++;
    end
    check("pwm_lit", lit, exp_lit);
    check("pwm_dark_seg", bad, 32'd0);
  endtask

  initial begin
    rst = 1'b1; num = 16'h0; dp = 4'h0; blank_lz = 1'b0; update = 1'b0; brightness = 2'd3;
    step(2);
    check_digit("reset", 4'hF, 8'hFF);
    check("reset_pending", {31'd0, pending}, 32'd0);
    check("reset_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    step(1);
    check_digit("first_digit", 4'hE, 8'hC0);

    // Scan order
    do_update(16'h1234, 4'h0, 1'b0);
    check("scan_pending", {31'd0, pending}, 32'd1);
    wait_frame(n);
    check("scan_pending_clr", {31'd0, pending}, 32'd0);
    step(1);  check_digit("scan_d0", 4'hE, 8'h99);
    step(16); check_digit("scan_d1", 4'hD, 8'hB0);
    step(16); check_digit("scan_d2", 4'hB, 8'hA4);
    step(16); check_digit("scan_d3", 4'h7, 8'hF9);
    wait_frame(n);
    wait_frame(n);
    check("frame_period", n, 32'd64);

    // Tearing: update while digit 1 is showing
    step(17);
    do_update(16'hABCD, 4'h0, 1'b0);
    check("tear_pending", {31'd0, pending}, 32'd1);
    step(15); check_digit("tear_old_d2", 4'hB, 8'hA4);
    step(16); check_digit("tear_old_d3", 4'h7, 8'hF9);
    check("tear_pending_hold", {31'd0, pending}, 32'd1);
    wait_frame(n);
    check("tear_pending_clr", {31'd0, pending}, 32'd0);
    step(1);  check_digit("tear_d0", 4'hE, 8'hA1);
    step(16); check_digit("tear_d1", 4'hD, 8'hC6);
    step(16); check_digit("tear_d2", 4'hB, 8'h83);
    step(16); check_digit("tear_d3", 4'h7, 8'h88);

    // Leading-zero blanking
    do_update(16'h0050, 4'b0001, 1'b1);
    wait_frame(n);
    step(1);  check_digit("blz_d0", 4'hE, 8'h40);
    step(16); check_digit("blz_d1", 4'hD, 8'h92);
    step(16); check_digit("blz_d2", 4'hB, 8'hFF);
    step(16); check_digit("blz_d3", 4'h7, 8'hFF);
    do_update(16'h0000, 4'b0001, 1'b1);
    wait_frame(n);
    step(1);  check_digit("blz0_d0", 4'hE, 8'h40);
    step(16); check_digit("blz0_d1", 4'hD, 8'hFF);

    // Last of several updates wins
    do_update(16'h1111, 4'h0, 1'b0);
    step(3);
    do_update(16'h2222, 4'h0, 1'b0);
    wait_frame(n);
    step(1);  check_digit("multi_d0", 4'hE, 8'hA4);

    // Update coinciding with the boundary tick
    do_update(16'h4444, 4'h0, 1'b0);
    step(61);
    num = 16'h3333; update = 1'b1;
    step(1);
    update = 1'b0;
    check("coin_fd", {31'd0, frame_done}, 32'd1);
    check("coin_pending", {31'd0, pending}, 32'd1);
    step(1);  check_digit("coin_old", 4'hE, 8'h99);
    wait_frame(n);
    check("coin_pending_clr", {31'd0, pending}, 32'd0);
    step(1);  check_digit("coin_new", 4'hE, 8'hB0);

    // PWM duty
    pwm(2'd0, 4);
    pwm(2'd1, 8);
    pwm(2'd2, 12);
    pwm(2'd3, 16);

    // Reset with a value pending during digit 2
    wait_frame(n);
    step(33);
    do_update(16'h5555, 4'h0, 1'b0);
    check("rst_pre_pending", {31'd0, pending}, 32'd1);
    rst = 1'b1;
    step(1);
    check_digit("rst_mid", 4'hF, 8'hFF);
    check("rst_mid_pending", {31'd0, pending}, 32'd0);
    check("rst_mid_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    step(1);  check_digit("rst_first", 4'hE, 8'hC0);
    wait_frame(n);
    step(1);  check_digit("rst_discard", 4'hE, 8'hC0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
